gpio_bank: RTL and testbench



---
 rtl/gpio_bank.sv | 144 ++++++++++++++
 tb/tb_gpio_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_bank.sv
// Multi-channel GPIO bank: per-pin OUT/DIR/IEN, atomic set/clear, synchronised
// inputs, sticky rise/fall capture with W1C, and a registered interrupt.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wen,
    input  logic [7:0]                   waddr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         ren,
    input  logic [7:0]                   raddr,
    output logic [WIDTH-1:0]             rdata,
    input  logic [CHANNELS*WIDTH-1:0]    phyin,
    output logic [CHANNELS*WIDTH-1:0]    phyout,
    output logic [CHANNELS*WIDTH-1:0]    phyoe,
    output logic                         irq
);

    localparam int N = CHANNELS * WIDTH;

    localparam logic [2:0] REG_OUT  = 3'd0;
    localparam logic [2:0] REG_IN   = 3'd1;
    localparam logic [2:0] REG_DIR  = 3'd2;
    localparam logic [2:0] REG_IEN  = 3'd3;
    localparam logic [2:0] REG_RISE = 3'd4;
    localparam logic [2:0] REG_FALL = 3'd5;
    localparam logic [2:0] REG_SET  = 3'd6;
    localparam logic [2:0] REG_CLR  = 3'd7;

    localparam logic [2:0] PRIME_DONE = 3'(SYNC_STAGES + 1);

    logic [N-1:0] out_q, out_d;
    logic [N-1:0] dir_q, dir_d;
    logic [N-1:0] ien_q, ien_d;
    logic [N-1:0] rise_q, rise_d;
    logic [N-1:0] fall_q, fall_d;
    logic [N-1:0] rise_clr, fall_clr;
    logic [N-1:0] prev_q;
    logic [SYNC_STAGES-1:0][N-1:0] sync_q;
    logic [N-1:0] sync_in;
    logic [2:0]   prime_q;
    logic         capture_en;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic         irq_q;

    // Byte-lane bits of the offset carry no meaning for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{waddr[1:0], raddr[1:0]};

    assign sync_in    = sync_q[SYNC_STAGES-1];
    assign capture_en = (prime_q == PRIME_DONE);

    // Bus strobes: wen/ren are single-cycle qualifiers with no back-pressure;
    // a write commits on the edge it is sampled, a read answers one cycle later.
    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        ien_d    = ien_q;
        rise_clr = '0;
        fall_clr = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wen && (waddr[7:5] == 3'(c))) begin
                case (waddr[4:2])
                    REG_OUT:  out_d[c*WIDTH +: WIDTH]    = wdata;
                    REG_DIR:  dir_d[c*WIDTH +: WIDTH]    = wdata;
                    REG_IEN:  ien_d[c*WIDTH +: WIDTH]    = wdata;
                    REG_RISE: rise_clr[c*WIDTH +: WIDTH] = wdata;
                    REG_FALL: fall_clr[c*WIDTH +: WIDTH] = wdata;
                    REG_SET:  out_d[c*WIDTH +: WIDTH]    = out_q[c*WIDTH +: WIDTH] | wdata;
                    REG_CLR:  out_d[c*WIDTH +: WIDTH]    = out_q[c*WIDTH +: WIDTH] & ~wdata;
                    default:  ;
                endcase
            end
        end
        // A fresh edge overrides a same-cycle W1C so no event is dropped.
        rise_d = (rise_q & ~rise_clr) | (capture_en ? (sync_in & ~prev_q) : '0);
        fall_d = (fall_q & ~fall_clr) | (capture_en ? (~sync_in & prev_q) : '0);
    end

    always_comb begin
        rdata_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ren && (raddr[7:5] == 3'(c))) begin
                case (raddr[4:2])
                    REG_OUT:  rdata_d = out_q[c*WIDTH +: WIDTH];
                    REG_IN:   rdata_d = sync_in[c*WIDTH +: WIDTH];
                    REG_DIR:  rdata_d = dir_q[c*WIDTH +: WIDTH];
                    REG_IEN:  rdata_d = ien_q[c*WIDTH +: WIDTH];
                    REG_RISE: rdata_d = rise_q[c*WIDTH +: WIDTH];
                    REG_FALL: rdata_d = fall_q[c*WIDTH +: WIDTH];
                    default:  rdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], phyin};
            prev_q <= sync_in;
        end
    end

    // Edge capture stays off until the synchroniser holds real pad levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_q <= '0;
        end else if (!capture_en) begin
            prime_q <= prime_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            rdata_q <= rdata_d;
            irq_q   <= |((rise_q | fall_q) & ien_q);
        end
    end

    assign rdata  = rdata_q;
    assign phyout = out_q;
    assign phyoe  = dir_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank (WIDTH=8, CHANNELS=2, SYNC_STAGES=2).
module tb_gpio_bank;

    logic        clk;
    logic        rst_n;
    logic        wen;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic        ren;
    logic [7:0]  raddr;
    logic [7:0]  rdata;
    logic [15:0] phyin;
    logic [15:0] phyout;
    logic [15:0] phyoe;
    logic        irq;

    int checks;
    int failures;

    gpio_bank #(.WIDTH(8), .CHANNELS(2), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .wen    (wen),
        .waddr  (waddr),
        .wdata  (wdata),
        .ren    (ren),
        .raddr  (raddr),
        .rdata  (rdata),
        .phyin  (phyin),
        .phyout (phyout),
        .phyoe  (phyoe),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        wen = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        wen = 1'b0;
    endtask

    task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        ren = 1'b1; raddr = a;
        @(negedge clk);
        ren = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset(input logic [15:0] pins);
        rst_n = 1'b0;
        phyin = pins;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        do_reset(16'hFFFF);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%h exp=0", irq); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
        checks++; if (phyout !== 16'h0000) begin failures++; $display("FAIL reset_phyout got=%h exp=0000", phyout); end
        checks++; if (phyoe !== 16'h0000) begin failures++; $display("FAIL reset_phyoe got=%h exp=0000", phyoe); end
        read_reg(8'h10, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_rise_ch0 got=%h exp=00", rd); end
        read_reg(8'h14, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_fall_ch0 got=%h exp=00", rd); end
        read_reg(8'h30, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL reset_rise_ch1 got=%h exp=00", rd); end
        read_reg(8'h04, rd);
        checks++; if (rd !== 8'hFF) begin failures++; $display("FAIL reset_in_ch0 got=%h exp=ff", rd); end
    endtask

    task automatic test_write_read();
        logic [7:0] rd;
        write_reg(8'h28, 8'hF0);
        write_reg(8'h20, 8'h5A);
        checks++; if (phyoe !== 16'hF000) begin failures++; $display("FAIL dir_ch1 got=%h exp=f000", phyoe); end
        checks++; if (phyout !== 16'h5A00) begin failures++; $display("FAIL out_ch1 got=%h exp=5a00", phyout); end
        write_reg(8'h38, 8'h01);
        checks++; if (phyout !== 16'h5B00) begin failures++; $display("FAIL set_ch1 got=%h exp=5b00", phyout); end
        write_reg(8'h3C, 8'h0A);
        checks++; if (phyout !== 16'h5100) begin failures++; $display("FAIL clr_ch1 got=%h exp=5100", phyout); end
        read_reg(8'h20, rd);
        checks++; if (rd !== 8'h51) begin failures++; $display("FAIL read_out_ch1 got=%h exp=51", rd); end
        read_reg(8'h28, rd);
        checks++; if (rd !== 8'hF0) begin failures++; $display("FAIL read_dir_ch1 got=%h exp=f0", rd); end
        read_reg(8'h38, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL read_set_ch1 got=%h exp=00", rd); end
    endtask

    task automatic test_ren_zero();
        logic [7:0] rd;
        read_reg(8'h20, rd);
        checks++; if (rd !== 8'h51) begin failures++; $display("FAIL ren_pre got=%h exp=51", rd); end
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL ren_zero got=%h exp=00", rdata); end
    endtask

    task automatic test_input();
        @(negedge clk);
        phyin[3:0] = 4'h9;
        ren = 1'b1; raddr = 8'h04;
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL in_cycle1 got=%h exp=00", rdata); end
        @(negedge clk);
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL in_cycle2 got=%h exp=00", rdata); end
        @(negedge clk);
        checks++; if (rdata !== 8'h09) begin failures++; $display("FAIL in_cycle3 got=%h exp=09", rdata); end
        ren = 1'b0;
    endtask

    task automatic test_edge_irq();
        logic [7:0] rd;
        @(negedge clk);
        phyin = 16'h0000;
        repeat (5) @(negedge clk);
        write_reg(8'h10, 8'hFF);
        write_reg(8'h14, 8'hFF);
        read_reg(8'h10, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL w1c_all_rise got=%h exp=00", rd); end
        write_reg(8'h0C, 8'h01);
        @(negedge clk);
        phyin[0] = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_at_capture got=%h exp=0", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_after_capture got=%h exp=1", irq); end
        phyin[0] = 1'b0;
        repeat (5) @(negedge clk);
        read_reg(8'h10, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL rise_pulse got=%h exp=01", rd); end
        read_reg(8'h14, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL fall_pulse got=%h exp=01", rd); end
        write_reg(8'h10, 8'h01);
        read_reg(8'h10, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL rise_w1c got=%h exp=00", rd); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_fall_pending got=%h exp=1", irq); end
        write_reg(8'h14, 8'h01);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_same_cycle_w1c got=%h exp=1", irq); end
        @(negedge clk);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_cleared got=%h exp=0", irq); end
    endtask

    task automatic test_collision();
        logic [7:0] rd;
        @(negedge clk);
        phyin[0] = 1'b1;
        repeat (5) @(negedge clk);
        phyin[0] = 1'b0;
        repeat (5) @(negedge clk);
        write_reg(8'h14, 8'h01);
        @(negedge clk);
        phyin[0] = 1'b1;
        repeat (2) @(negedge clk);
        wen = 1'b1; waddr = 8'h10; wdata = 8'h01;
        @(negedge clk);
        wen = 1'b0;
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL collision_irq got=%h exp=1", irq); end
        read_reg(8'h10, rd);
        checks++; if (rd !== 8'h01) begin failures++; $display("FAIL collision_rise got=%h exp=01", rd); end
        read_reg(8'h14, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL collision_fall got=%h exp=00", rd); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL collision_irq_hold got=%h exp=1", irq); end
    endtask

    task automatic test_decode();
        logic [7:0] rd;
        write_reg(8'h40, 8'hFF);
        write_reg(8'h48, 8'hFF);
        checks++; if (phyout !== 16'h5100) begin failures++; $display("FAIL absent_out got=%h exp=5100", phyout); end
        checks++; if (phyoe !== 16'hF000) begin failures++; $display("FAIL absent_dir got=%h exp=f000", phyoe); end
        read_reg(8'h40, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL absent_read_out got=%h exp=00", rd); end
        read_reg(8'h50, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL absent_read_rise got=%h exp=00", rd); end
        read_reg(8'h23, rd);
        checks++; if (rd !== 8'h51) begin failures++; $display("FAIL lsb_ignored got=%h exp=51", rd); end
    endtask

    task automatic test_async_reset();
        logic [7:0] rd;
        @(negedge clk);
        ren = 1'b1; raddr = 8'h20;
        wen = 1'b1; waddr = 8'h3C; wdata = 8'h00;
        @(negedge clk);
        checks++; if (rdata !== 8'h51) begin failures++; $display("FAIL burst_rdata got=%h exp=51", rdata); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (phyout !== 16'h0000) begin failures++; $display("FAIL async_phyout got=%h exp=0000", phyout); end
        checks++; if (phyoe !== 16'h0000) begin failures++; $display("FAIL async_phyoe got=%h exp=0000", phyoe); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL async_irq got=%h exp=0", irq); end
        checks++; if (rdata !== 8'h00) begin failures++; $display("FAIL async_rdata got=%h exp=00", rdata); end
        ren = 1'b0; wen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        read_reg(8'h10, rd);
        checks++; if (rd !== 8'h00) begin failures++; $display("FAIL post_reset_rise got=%h exp=00", rd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL post_reset_irq got=%h exp=0", irq); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        wen   = 1'b0;
        waddr = '0;
        wdata = '0;
        ren   = 1'b0;
        raddr = '0;
        phyin = '0;
        test_reset();
        do_reset(16'h0000);
        test_write_read();
        test_ren_zero();
        test_input();
        test_edge_irq();
        test_collision();
        test_decode();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
